icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 SETS, default 16, number of direct-mapped frames (power of two, 1 word per frame); index = imemaddr[$clog2(SETS)+1:2], tag = imemaddr[31:$clog2(SETS)+2], bits [1:0] ignored.
REQ-002 CLK  input  1  single clock, all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 imemREN  input  1  datapath instruction read request.
REQ-005 imemaddr  input  32  datapath fetch address (word aligned).
REQ-006 ihit  output  1  requested word valid on imemload this cycle.
REQ-007 imemload  output  32  instruction word returned to datapath.
REQ-008 iREN  output  1  read request to memory controller.
REQ-009 iaddr  output  32  memory read address.
REQ-010 iwait  input  1  memory busy; data on iload valid in the cycle iwait=0 while iREN=1.
REQ-011 iload  input  32  memory read data.
REQ-012 hit_count  output  32  saturating count of completed hits.
REQ-013 miss_count  output  32  saturating count of misses entered.

Function
REQ-014 Storage per frame: valid (1), tag (32-2-log2 SETS), data (32).
REQ-015 Two states: IDLE, FETCH.
REQ-016 IDLE, imemREN=1, frame valid and tag match: ihit=1 and imemload=frame data combinationally in the same cycle (zero-cycle hit); state stays IDLE; hit_count increments.
REQ-017 IDLE, imemREN=1, miss (invalid or tag mismatch): ihit=0; miss_addr register captures {imemaddr[31:2],2'b00}; next state FETCH; miss_count increments.
REQ-018 IDLE, imemREN=0: ihit=0, iREN=0, no state change, no counter change.
REQ-019 FETCH: iREN=1, iaddr=miss_addr, ihit=0, imemload=0, regardless of imemaddr/imemREN.
REQ-020 FETCH, iwait=1: remain in FETCH, no frame write.
REQ-021 FETCH, iwait=0: frame at miss_addr index written valid=1, tag=miss_addr tag, data=iload; next state IDLE.
REQ-022 Miss latency: a miss with memory wait W cycles yields ihit in the cycle after the fill edge, i.e. W+2 cycles after the miss cycle for an unchanged address.
REQ-023 imemaddr changing or imemREN dropping during FETCH: fill still completes for miss_addr; the new address is looked up in IDLE afterwards (no abort).
REQ-024 Fill replaces any previous frame contents at that index (conflict eviction, no write-back; instruction cache is read-only).
REQ-025 When ihit=0, imemload=0; in IDLE iREN=0 and iaddr=miss_addr (held).
REQ-026 Counters saturate at 32'hFFFFFFFF; never wrap.
REQ-027 No data is forwarded from iload to imemload on the fill cycle.

Reset
REQ-028 nRST low asynchronously forces: state IDLE, all valid bits 0, miss_addr 0, hit_count 0, miss_count 0; hence ihit=0, iREN=0, iaddr=0, imemload=0.
REQ-029 Reset during FETCH abandons the fill; no frame is written; tags/data need not be cleared.
REQ-030 First request after reset is always a miss.

Verification
REQ-031 Cold miss: after reset, imemREN=1, imemaddr=0x00000040, iwait high 3 cycles then low with iload=0x8C220004 -> iREN=1/iaddr=0x40 for 4 cycles, ihit=1 with imemload=0x8C220004 next cycle, miss_count=1, hit_count=1.
REQ-032 Conflict eviction (SETS=16): fill 0x00000040, then request 0x00000440 (same index 0, different tag) -> miss, refill; re-request 0x40 -> miss again; miss_count=3.
REQ-033 Address change mid-fill: miss on 0x10, switch imemaddr to 0x20 while iwait=1 -> iaddr stays 0x10, frame 4 filled, then miss issued for 0x20.
REQ-034 Back-to-back hits: fill 0x0,0x4,0x8, then request each for one cycle -> ihit=1 every cycle, iREN=0, hit_count +3.
REQ-035 Reset mid-FETCH: assert nRST low while iREN=1 -> iREN=0 immediately (same cycle); after release request same address -> miss.
REQ-036 imemREN=0 with matching valid frame -> ihit=0, counters unchanged.

Source files
------------

// File: rtl/icache_if.sv
// Instruction cache bus bundle: datapath fetch side, memory-controller read
// side and the performance counters, grouped so the cache takes one port.
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    // Cache side: serves fetches, issues memory reads, exports counters.
    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    // Environment side: datapath plus memory controller.
    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame, read-only instruction cache.
// Hits return data combinationally in IDLE; a miss parks the line address in
// miss_addr_r and the FETCH state holds the memory read until iwait drops,
// then fills the frame and returns to IDLE, where the lookup is retried.
module icache #(
    parameter int SETS = 16
) (
    input  logic     CLK,
    input  logic     nRST,
    icache_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            state_r;
    logic [31:0]       miss_addr_r;
    logic [31:0]       hit_count_r;
    logic [31:0]       miss_count_r;
    logic [SETS-1:0]   valid_r;
    logic [TAG_W-1:0]  tag_r  [SETS];
    logic [31:0]       data_r [SETS];

    logic [IDX_W-1:0]  req_idx_s;
    logic [TAG_W-1:0]  req_tag_s;
    logic [IDX_W-1:0]  fill_idx_s;
    logic [TAG_W-1:0]  fill_tag_s;
    logic              hit_s;
    logic              miss_s;
    logic              fill_s;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

    assign req_idx_s  = bus.imemaddr[IDX_W+1:2];
    assign req_tag_s  = bus.imemaddr[31:IDX_W+2];
    assign fill_idx_s = miss_addr_r[IDX_W+1:2];
    assign fill_tag_s = miss_addr_r[31:IDX_W+2];

    // Classify the current cycle: hit or miss in IDLE, fill completion in FETCH.
    always_comb begin
        hit_s  = 1'b0;
        miss_s = 1'b0;
        fill_s = 1'b0;
        if (state_r == IDLE) begin
            if (bus.imemREN) begin
                if (valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s)) begin
                    hit_s = 1'b1;
                end else begin
                    miss_s = 1'b1;
                end
            end else begin
                hit_s = 1'b0;
            end
        end else begin
            fill_s = ~bus.iwait;
        end
    end

    // Controller: state, miss address, valid bits and saturating counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r      <= IDLE;
            miss_addr_r  <= 32'h0000_0000;
            hit_count_r  <= 32'h0000_0000;
            miss_count_r <= 32'h0000_0000;
            valid_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hit_s) begin
                        hit_count_r <= sat_inc(hit_count_r);
                    end else if (miss_s) begin
                        miss_addr_r  <= {bus.imemaddr[31:2], 2'b00};
                        miss_count_r <= sat_inc(miss_count_r);
                        state_r      <= FETCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    if (fill_s) begin
                        valid_r[fill_idx_s] <= 1'b1;
                        state_r             <= IDLE;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Frame tag/data arrays: written only by a completed fill, never cleared.
    always_ff @(posedge CLK) begin
        if (fill_s) begin
            tag_r[fill_idx_s]  <= fill_tag_s;
            data_r[fill_idx_s] <= bus.iload;
        end else begin
            tag_r[fill_idx_s]  <= tag_r[fill_idx_s];
            data_r[fill_idx_s] <= data_r[fill_idx_s];
        end
    end

    // Zero-cycle hit path; nothing is forwarded from iload on the fill cycle.
    assign bus.ihit       = hit_s;
    assign bus.imemload   = hit_s ? data_r[req_idx_s] : 32'h0000_0000;
    assign bus.iREN       = (state_r == FETCH);
    assign bus.iaddr      = miss_addr_r;
    assign bus.hit_count  = hit_count_r;
    assign bus.miss_count = miss_count_r;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: expected fetch data is queued when a fill or hit
// request is driven and popped when the cache raises ihit.
module tb_icache;
    logic CLK;
    logic nRST;
    icache_if bus();

    icache #(.SETS(16)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hits = 32'd0;
    logic [31:0] exp_misses = 32'd0;
    logic [31:0] sb_q[$];

    // Global watchdog so the run can never hang.
    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare a hit cycle against the oldest queued expectation.
    task automatic pop_hit(input string tag);
        logic [31:0] exp_d;
        check({tag, "_ihit"}, {31'd0, bus.ihit}, 32'd1);
        check({tag, "_iren"}, {31'd0, bus.iREN}, 32'd0);
        if (sb_q.size() > 0) begin
            exp_d = sb_q.pop_front();
            check({tag, "_data"}, bus.imemload, exp_d);
        end else begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end
    endtask

    // Wait a bounded number of cycles for ihit, then score it.
    task automatic wait_hit(input string tag, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            sample();
            if (bus.ihit) begin
                found = 1'b1;
                break;
            end
            check({tag, "_wait_load"}, bus.imemload, 32'd0);
            step();
        end
        if (found) begin
            pop_hit(tag);
        end else begin
            check({tag, "_hit_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic check_counts(input string tag);
        sample();
        check({tag, "_hit_count"}, bus.hit_count, exp_hits);
        check({tag, "_miss_count"}, bus.miss_count, exp_misses);
        step();
    endtask

    // Full miss/fill/hit sequence for one address with w wait cycles.
    task automatic fill(input string tag, input logic [31:0] a, input logic [31:0] d, input int w);
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        bus.iwait    = 1'b1;
        sample();
        check({tag, "_miss_ihit"}, {31'd0, bus.ihit}, 32'd0);
        check({tag, "_miss_iren"}, {31'd0, bus.iREN}, 32'd0);
        step();
        exp_misses++;
        for (int i = 0; i < w; i++) begin
            sample();
            check({tag, "_fetch_iren"}, {31'd0, bus.iREN}, 32'd1);
            check({tag, "_fetch_iaddr"}, bus.iaddr, {a[31:2], 2'b00});
            check({tag, "_fetch_ihit"}, {31'd0, bus.ihit}, 32'd0);
            step();
        end
        bus.iwait = 1'b0;
        bus.iload = d;
        sample();
        check({tag, "_fill_iren"}, {31'd0, bus.iREN}, 32'd1);
        check({tag, "_fill_noforward"}, bus.imemload, 32'd0);
        step();
        bus.iwait = 1'b1;
        bus.iload = 32'hDEAD_BEEF;
        sb_q.push_back(d);
        wait_hit(tag, 3);
        exp_hits++;
        step();
        bus.imemREN = 1'b0;
    endtask

    initial begin
        nRST         = 1'b0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        bus.iwait    = 1'b1;
        bus.iload    = 32'h0;
        step();
        step();
        sample();
        check("rst_ihit", {31'd0, bus.ihit}, 32'd0);
        check("rst_iren", {31'd0, bus.iREN}, 32'd0);
        check("rst_iaddr", bus.iaddr, 32'd0);
        check("rst_imemload", bus.imemload, 32'd0);
        check("rst_hit_count", bus.hit_count, 32'd0);
        check("rst_miss_count", bus.miss_count, 32'd0);
        step();
        nRST = 1'b1;
        step();

        // Cold miss with three wait cycles.
        fill("cold", 32'h0000_0040, 32'h8C22_0004, 3);
        check_counts("cold");
        check("cold_iaddr_held", bus.iaddr, 32'h0000_0040);

        // Conflict eviction at index 0.
        fill("conf_440", 32'h0000_0440, 32'h1111_2222, 1);
        fill("conf_40", 32'h0000_0040, 32'h3333_4444, 0);
        check_counts("conflict");
        check("conflict_miss3", bus.miss_count, 32'd3);

        // Address change while the fill for 0x10 is pending.
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0010;
        bus.iwait    = 1'b1;
        sample();
        check("chg_miss_ihit", {31'd0, bus.ihit}, 32'd0);
        step();
        exp_misses++;
        bus.imemaddr = 32'h0000_0020;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("chg_iren", {31'd0, bus.iREN}, 32'd1);
            check("chg_iaddr", bus.iaddr, 32'h0000_0010);
            check("chg_ihit", {31'd0, bus.ihit}, 32'd0);
            step();
        end
        bus.iwait = 1'b0;
        bus.iload = 32'hAAAA_0010;
        step();
        bus.iwait = 1'b1;
        sample();
        check("chg_new_miss_ihit", {31'd0, bus.ihit}, 32'd0);
        check("chg_new_miss_iren", {31'd0, bus.iREN}, 32'd0);
        step();
        exp_misses++;
        sample();
        check("chg_new_iaddr", bus.iaddr, 32'h0000_0020);
        check("chg_new_iren", {31'd0, bus.iREN}, 32'd1);
        bus.iwait = 1'b0;
        bus.iload = 32'hBBBB_0020;
        step();
        bus.iwait = 1'b1;
        sb_q.push_back(32'hBBBB_0020);
        wait_hit("chg_hit20", 2);
        exp_hits++;
        step();
        bus.imemaddr = 32'h0000_0010;
        sb_q.push_back(32'hAAAA_0010);
        sample();
        pop_hit("chg_hit10");
        exp_hits++;
        step();
        bus.imemREN = 1'b0;
        check_counts("chg");

        // Back-to-back single-cycle hits.
        fill("b2b_0", 32'h0000_0000, 32'hC0DE_0000, 0);
        fill("b2b_4", 32'h0000_0004, 32'hC0DE_0004, 2);
        fill("b2b_8", 32'h0000_0008, 32'hC0DE_0008, 1);
        for (int k = 0; k < 3; k++) begin
            bus.imemREN  = 1'b1;
            bus.imemaddr = 32'(k * 4);
            sb_q.push_back(32'hC0DE_0000 + 32'(k * 4));
            sample();
            pop_hit("b2b_hit");
            exp_hits++;
            step();
        end
        bus.imemREN = 1'b0;
        check_counts("b2b");

        // No request with a matching valid frame.
        bus.imemaddr = 32'h0000_0008;
        sample();
        check("noreq_ihit", {31'd0, bus.ihit}, 32'd0);
        check("noreq_load", bus.imemload, 32'd0);
        step();
        check_counts("noreq");

        // Reset in the middle of a fetch.
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_008C;
        sample();
        step();
        sample();
        check("rstmid_iren_before", {31'd0, bus.iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        check("rstmid_iren", {31'd0, bus.iREN}, 32'd0);
        check("rstmid_iaddr", bus.iaddr, 32'd0);
        check("rstmid_hits", bus.hit_count, 32'd0);
        step();
        step();
        nRST       = 1'b1;
        exp_hits   = 32'd0;
        exp_misses = 32'd0;
        fill("rstmid_8c", 32'h0000_008C, 32'h5A5A_008C, 1);
        fill("rstmid_0", 32'h0000_0000, 32'h7777_0000, 0);
        check_counts("rstmid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
